keypad_scanner: RTL and testbench

//   Input-side counterpart of the display multiplexer: scans a 4x4 matrix keypad by driving one

---
 rtl/kp_pkg.sv | 26 ++
 rtl/scan_tick_gen.sv | 24 ++
 rtl/keypad_scanner.sv | 164 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared definitions for the keypad scanner: matrix geometry, FSM states and
// the row-priority helper.
package kp_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  // Index of the lowest-numbered active-low row; callers guarantee one is low.
  function automatic logic [1:0] lowest_low(input logic [ROWS-1:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks;
// each tick ends one column dwell period.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, debounced press
// and release, one key code per press over a valid/ack handshake.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_held,
  output logic             overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic             tick;
  logic [ROWS-1:0]  sync1_q, rows_s_q;
  kp_state_e        state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             ovr_q, ovr_d;
  logic             ack_take, row_low, confirm, release_done;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '1;
      rows_s_q <= '1;
    end else begin
      sync1_q  <= row_n;
      rows_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    valid_d      = valid_q;
    held_d       = held_q;
    ovr_d        = ovr_q;
    confirm      = 1'b0;
    release_done = 1'b0;
    ack_take     = key_ack & valid_q;
    row_low      = ~rows_s_q[row_q];

    if (ack_take) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (!(&rows_s_q)) begin
            row_d = lowest_low(rows_s_q);
            if (DEBOUNCE_SCANS == 1) begin
              confirm = 1'b1;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_low) begin
            if (cnt_q == CNT_LAST) confirm = 1'b1;
            else                   cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (!row_low) begin
            if (DEBOUNCE_SCANS == 1) begin
              release_done = 1'b1;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!row_low) begin
            if (cnt_q == CNT_LAST) release_done = 1'b1;
            else                   cnt_d        = cnt_q + CNT_W'(1);
          end else begin
            cnt_d   = '0;
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    // An ack in the same cycle consumed the old code, so it cannot overrun.
    if (confirm) begin
      code_d  = {row_d, col_q};
      valid_d = 1'b1;
      held_d  = 1'b1;
      ovr_d   = ovr_d | (valid_q & ~ack_take);
      cnt_d   = '0;
      state_d = HELD;
    end

    if (release_done) begin
      held_d  = 1'b0;
      cnt_d   = '0;
      col_d   = col_q + 2'd1;
      state_d = SCAN;
    end
  end

  assign col_n     = ~(COLS'(1) << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix model driven by press/bounce
// episodes, with a scoreboard of expected reports checked by a monitor.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_n, col_n, key_code;
  logic       key_valid, key_held, overrun;
  logic       key_ack = 1'b0;

  logic       pressed = 1'b0;
  logic [1:0] pr = 2'd0, pc = 2'd0;
  bit         prev_unacked = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] code;
    logic       ovr;
  } exp_t;
  exp_t exp_q[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  // Switch matrix: a closed switch pulls its row low only while its column is driven.
  always_comb begin
    row_n = 4'hF;
    if (pressed && !col_n[pc]) row_n[pr] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a report is a rising key_valid, or an overrun overwrite while valid.
  logic prev_v = 1'b0, prev_o = 1'b0;
  always @(negedge clock) begin : mon
    exp_t e;
    if (key_valid && (!prev_v || (overrun && !prev_o))) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_report: got code %0h, expected no report", key_code);
      end else begin
        e = exp_q.pop_front();
        chk("report_code", key_code, e.code);
        chk("report_overrun", overrun, e.ovr);
        chk("report_held", key_held, 1);
      end
    end
    prev_v <= key_valid;
    prev_o <= overrun;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_ack();
    @(negedge clock);
    key_ack = 1'b1;
    @(posedge clock);
    #1;
    key_ack = 1'b0;
    chk("valid_after_ack", key_valid, 0);
    chk("overrun_after_ack", overrun, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_col_n", col_n, 4'hE);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_held", key_held, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  task automatic wait_col(input logic [3:0] want, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (col_n == want) found = 1'b1;
    end
    chk("wait_col", found, 1);
  endtask

  // One key episode: optional press glitches (at most 2 tick samples each),
  // stable press, optional release glitches, stable release, optional ack.
  task automatic episode(input logic [1:0] r, input logic [1:0] c,
                         input int n_pg, input int n_rg, input bit ack_it);
    logic [3:0] col_exp;
    exp_t       e;
    col_exp = ~(4'b0001 << c);
    pr = r;
    pc = c;
    e.code = {r, c};
    e.ovr  = prev_unacked;
    exp_q.push_back(e);
    repeat (n_pg) begin
      pressed = 1'b1; cyc($urandom_range(1, 2 * SD));
      pressed = 1'b0; cyc($urandom_range(2 * SD, 3 * SD));
    end
    pressed = 1'b1;
    cyc(60);
    chk("col_frozen", col_n, col_exp);
    chk("held_while_pressed", key_held, 1);
    chk("valid_while_pressed", key_valid, 1);
    repeat (n_rg) begin
      pressed = 1'b0; cyc($urandom_range(1, 2 * SD));
      pressed = 1'b1; cyc($urandom_range(2 * SD, 3 * SD));
    end
    chk("held_through_bounce", key_held, 1);
    pressed = 1'b0;
    cyc(40);
    chk("held_after_release", key_held, 0);
    if (ack_it) do_ack();
    prev_unacked = !ack_it;
  endtask

  initial begin
    bit         found;
    logic [3:0] col_exp;
    exp_t       e;

    // Reset and idle column rotation.
    #1 reset = 1'b1;
    #1 check_reset_vals();
    cyc(2);
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      col_exp = ~(4'b0001 << ((n / SD) % 4));
      chk("idle_col_n", col_n, col_exp);
    end
    chk("idle_no_valid", key_valid, 0);

    // Directed episodes.
    episode(2'd2, 2'd1, 0, 0, 1'b1);
    episode(2'd0, 2'd3, 1, 3, 1'b1);
    episode(2'd0, 2'd0, 0, 0, 1'b0);
    episode(2'd3, 2'd3, 0, 0, 1'b1);

    // Randomized episodes.
    for (int k = 0; k < 14; k++) begin
      bit ack_it;
      ack_it = prev_unacked ? 1'b1 : ($urandom_range(0, 2) != 0);
      episode(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 2), $urandom_range(0, 3), ack_it);
    end

    // Reset while debouncing: nothing reported before reset, one report after.
    pr = 2'd1;
    pc = 2'd2;
    wait_col(4'b1110, found);
    pressed = 1'b1;
    wait_col(4'b1011, found);
    cyc(6);
    #1 reset = 1'b1;
    #1 check_reset_vals();
    prev_unacked = 1'b0;
    cyc(2);
    e.code = 4'h6;
    e.ovr  = 1'b0;
    exp_q.push_back(e);
    reset = 1'b0;
    cyc(60);
    chk("rst_deb_held", key_held, 1);
    chk("rst_deb_code", key_code, 4'h6);

    // Reset while held: the still-pressed key is reported again.
    #1 reset = 1'b1;
    #1 check_reset_vals();
    cyc(2);
    exp_q.push_back(e);
    reset = 1'b0;
    cyc(60);
    chk("rst_held_valid", key_valid, 1);
    pressed = 1'b0;
    cyc(40);
    chk("rst_held_released", key_held, 0);
    do_ack();

    cyc(10);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
